// File: rtl/sync_fifo_param.sv
// Purpose: single-clock parameterised FIFO with occupancy count, almost-full/empty, sticky errors.
// Latency: FWFT=0 -> popped word registered one edge after pop; FWFT=1 -> head word visible after push edge.
// Backpressure: full_flag rejects a lone push (sets overflow); a push is still accepted when full if a pop completes.
//
// Ports:
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   write_enable/data  : push request and word
//   read_enable        : pop request (FWFT=1: acknowledge of the head word)
//   read_data/valid    : popped word (FWFT=0) or head word (FWFT=1) and its qualifier
//   empty_flag, full_flag, almost_full, almost_empty, count : occupancy status
//   overflow, underflow, clear_errors : sticky error flags and their clear
module sync_fifo_param #(
  parameter int  DATA_WIDTH    = 8,
  parameter int  DEPTH         = 16,
  parameter int  AFULL_THRESH  = 12,
  parameter int  AEMPTY_THRESH = 4,
  parameter bit  FWFT          = 1'b0,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  empty_flag,
  output logic                  full_flag,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_errors
);

  // Elaboration-time legality checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= AFULL_THRESH) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_THRESH must be in 0..AFULL_THRESH-1");
  end

  localparam logic [ADDR_WIDTH:0] LP_DEPTH  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LP_AFULL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LP_AEMPTY = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
  assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

  // Status flags decode the registered count so they move on the same edge.
  assign empty_flag   = (r_count == '0);
  assign full_flag    = (r_count == LP_DEPTH);
  assign almost_full  = (r_count >= LP_AFULL);
  assign almost_empty = (r_count <= LP_AEMPTY);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // A pop frees the head slot this edge, so a push into a full FIFO can land
  // in it; when full the head and tail addresses coincide and the read of the
  // old word happens before the write lands (non-blocking update).
  assign w_rd_acc = read_enable & ~empty_flag;
  assign w_wr_acc = write_enable & (~full_flag | w_rd_acc);

  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[w_wr_addr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Set has priority over clear when both happen in one cycle.
      r_overflow  <= (r_overflow  & ~clear_errors) | (write_enable & ~w_wr_acc);
      r_underflow <= (r_underflow & ~clear_errors) | (read_enable & empty_flag);
    end
  end

  if (FWFT == 1'b0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_valid;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_read_data  <= '0;
        r_read_valid <= 1'b0;
      end else begin
        r_read_valid <= w_rd_acc;
        if (w_rd_acc) r_read_data <= r_mem[w_rd_addr];
      end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
  end else begin : g_fwft_read
    // Head word falls through straight from the array.
    assign read_data  = r_mem[w_rd_addr];
    assign read_valid = ~empty_flag;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, write_enable, read_enable, clear_errors;
  logic [DW-1:0] write_data;

  // Registered-read instance
  logic [DW-1:0] rd0;
  logic          rv0, em0, fu0, af0, ae0, ov0, un0;
  logic [4:0]    cnt0;
  // FWFT instance, driven by the same stimulus
  logic [DW-1:0] rd1;
  logic          rv1, em1, fu1, af1, ae1, ov1, un1;
  logic [4:0]    cnt1;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1'b0)) u_reg (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(rd0), .read_valid(rv0), .empty_flag(em0),
    .full_flag(fu0), .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ov0), .underflow(un0), .clear_errors(clear_errors));

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(rd1), .read_valid(rv1), .empty_flag(em1),
    .full_flag(fu1), .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ov1), .underflow(un1), .clear_errors(clear_errors));

  // Behavioural model: contents as a queue, plus error flags and last pop.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd;
  bit            m_rv, m_ov, m_un;
  bit            chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one clock of stimulus and advance the model by the same edge.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit ce, input bit rst);
    bit was_empty, racc, wacc;
    write_enable = we; write_data = wd; read_enable = re; clear_errors = ce; reset = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_rd = '0; m_rv = 0; m_ov = 0; m_un = 0;
    end else begin
      was_empty = (mq.size() == 0);
      racc = re && !was_empty;
      wacc = we && (mq.size() < DEPTH || racc);
      m_rv = racc;
      if (racc) m_rd = mq.pop_front();
      if (wacc) mq.push_back(wd);
      m_ov = (m_ov && !ce) || (we && !wacc);
      m_un = (m_un && !ce) || (re && was_empty);
    end
    #1;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int sz;
      sz = mq.size();
      chk("count",        {27'd0, cnt0}, sz);
      chk("count_fwft",   {27'd0, cnt1}, sz);
      chk("empty",        {31'd0, em0}, (sz == 0));
      chk("full",         {31'd0, fu0}, (sz == DEPTH));
      chk("almost_full",  {31'd0, af0}, (sz >= 12));
      chk("almost_empty", {31'd0, ae0}, (sz <= 4));
      chk("flags_fwft",   {28'd0, em1, fu1, af1, ae1},
          {28'd0, 1'(sz == 0), 1'(sz == DEPTH), 1'(sz >= 12), 1'(sz <= 4)});
      chk("overflow",     {30'd0, ov0, ov1}, {30'd0, m_ov, m_ov});
      chk("underflow",    {30'd0, un0, un1}, {30'd0, m_un, m_un});
      chk("read_valid",   {31'd0, rv0}, m_rv);
      chk("read_data",    {24'd0, rd0}, {24'd0, m_rd});
      chk("read_valid_fwft", {31'd0, rv1}, (sz != 0));
      if (sz != 0) chk("read_data_fwft", {24'd0, rd1}, {24'd0, mq[0]});
    end
  end

  initial begin
    write_enable = 0; write_data = '0; read_enable = 0; clear_errors = 0; reset = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    // Reset state
    chk("rst_count", {27'd0, cnt0}, 0);
    chk("rst_flags", {em0, fu0, ae0, af0}, 4'b1010);
    chk("rst_read",  {rv0, rd0, rv1}, 10'h000);

    // 1: fill 0x01..0x10 then drain in order
    for (int i = 1; i <= 16; i++) begin
      step(1, DW'(i), 0, 0, 0);
      if (i == 11) chk("t1_af_at11", {31'd0, af0}, 0);
      if (i == 12) chk("t1_af_at12", {31'd0, af0}, 1);
    end
    chk("t1_full", {fu0, cnt0}, {1'b1, 5'd16});
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 0, 0);
      chk("t1_pop", {rv0, rd0}, {1'b1, DW'(i)});
      if (i == 11) chk("t1_ae_at5", {31'd0, ae0}, 0);
      if (i == 12) chk("t1_ae_at4", {31'd0, ae0}, 1);
    end
    step(0, 0, 0, 0, 0);
    chk("t1_drained", {em0, rv0, rd0}, {1'b1, 1'b0, 8'h10});

    // 2: overflow on full, then write-through with a simultaneous pop
    for (int i = 0; i < 16; i++) step(1, DW'(8'h20 + i), 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0);
    chk("t2_ovf", {ov0, cnt0}, {1'b1, 5'd16});
    step(1, 8'hBB, 1, 0, 0);
    chk("t2_wt", {ov0, cnt0, rv0, rd0}, {1'b1, 5'd16, 1'b1, 8'h20});
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
    chk("t2_last", {rv0, rd0}, {1'b1, 8'hBB});

    // 3: simultaneous push/pop while empty, then clear errors
    step(1, 8'h5C, 1, 0, 0);
    chk("t3_unf", {un0, cnt0, rv0}, {1'b1, 5'd1, 1'b0});
    step(0, 0, 1, 0, 0);
    chk("t3_pop", {rv0, rd0}, {1'b1, 8'h5C});
    step(0, 0, 0, 1, 0);
    chk("t3_clear", {ov0, un0, ov1, un1}, 4'b0000);
    step(0, 0, 1, 1, 0);
    chk("t3_set_wins", {31'd0, un0}, 1);
    step(0, 0, 0, 1, 0);

    // 4: random traffic with occupancy in 3..7 across pointer wrap
    for (int i = 0; i < 5; i++) step(1, DW'($urandom), 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      bit we, re;
      we = 1'($urandom);
      re = 1'($urandom);
      if (mq.size() <= 3) re = 0;
      if (mq.size() >= 7) we = 0;
      step(we, DW'($urandom), re, 0, 0);
    end
    for (int i = 0; i < 10 && mq.size() != 0; i++) step(0, 0, 1, 0, 0);
    chk("t4_empty", {31'd0, em0}, 1);

    // 5: first-word-fall-through behaviour
    step(1, 8'h11, 0, 0, 0);
    chk("t5_fall", {rv1, rd1}, {1'b1, 8'h11});
    step(1, 8'h22, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("t5_next", {rv1, rd1}, {1'b1, 8'h22});
    step(0, 0, 1, 0, 0);
    chk("t5_gone", {31'd0, rv1}, 0);

    // 6: reset mid-operation with count=9 and overflow set
    for (int i = 0; i < 17; i++) step(1, DW'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    chk("t6_pre", {ov0, cnt0}, {1'b1, 5'd9});
    step(1, 8'h77, 0, 0, 1);
    chk("t6_rst", {cnt0, em0, ov0, rv0, rv1}, {5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    step(0, 0, 0, 0, 0);
    chk("t6_nostore", {cnt0, em1}, {5'd0, 1'b1});

    step(0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
